event_capture_tx: RTL and testbench

//  Transmit side of the event path into Convolution2d: accepts input spike events from upstream,

---
 rtl/snn_interfaces_pkg.sv | 20 ++
 rtl/event_fifo.sv | 46 ++++
 rtl/event_capture_tx.sv | 127 ++++++++++++
 tb/tb_event_capture_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_interfaces_pkg.sv
// Shared event types and default geometry for the spiking conv event path.
package snn_interfaces_pkg;

  localparam int DEFAULT_COORD_BITS  = 8;
  localparam int DEFAULT_IN_CHANNELS = 2;
  localparam int DEFAULT_IMG_WIDTH   = 32;
  localparam int DEFAULT_IMG_HEIGHT  = 32;

  typedef struct packed {
    logic [DEFAULT_COORD_BITS-1:0]  x;
    logic [DEFAULT_COORD_BITS-1:0]  y;
    logic [DEFAULT_IN_CHANNELS-1:0] spikes;
  } event_t;

  typedef enum logic {
    OUT_EMPTY  = 1'b0,
    OUT_LOADED = 1'b1
  } out_state_t;

endpackage

// File: rtl/event_fifo.sv
// Generic synchronous circular FIFO. Pointers carry an extra wrap bit so that
// full and empty are distinguished without a separate occupancy register.
module event_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer advance; flush and reset collapse the buffer to empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !full && !rst && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/event_capture_tx.sv
// Event ingress for the convolution: filters malformed events, buffers the
// rest and hands them out one at a time on a registered valid/ready port.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   OUT_EMPTY  | output register idle, out_valid=0, loads FIFO head if any
//   OUT_LOADED | out_event held with out_valid=1 until taken; reloads on take
module event_capture_tx
  import snn_interfaces_pkg::*;
#(
  parameter int COORD_BITS  = DEFAULT_COORD_BITS,
  parameter int IN_CHANNELS = DEFAULT_IN_CHANNELS,
  parameter int IMG_WIDTH   = DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEFAULT_IMG_HEIGHT,
  parameter int FIFO_DEPTH  = 8,
  parameter int DROP_CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  event_t                        in_event,
  output logic                          out_valid,
  input  logic                          out_ready,
  output event_t                        out_event,
  input  logic                          flush,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic [DROP_CNT_W-1:0]         drop_count
);

  localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic [$bits(event_t)-1:0] fifo_head_raw;
  event_t                 fifo_head;
  logic [FILL_W-1:0]      fifo_count;
  out_state_t             state;

  logic                   in_fire;
  logic                   ev_ok;
  logic [COORD_BITS:0]    x_ext;
  logic [COORD_BITS:0]    y_ext;
  logic [IN_CHANNELS-1:0] spikes;

  assign x_ext  = {1'b0, in_event.x};
  assign y_ext  = {1'b0, in_event.y};
  assign spikes = in_event.spikes;
  assign ev_ok  = (x_ext < (COORD_BITS+1)'(IMG_WIDTH)) &&
                  (y_ext < (COORD_BITS+1)'(IMG_HEIGHT)) &&
                  (spikes != '0);

  // Ready depends only on registered occupancy; a same-cycle pop never frees a slot.
  assign in_ready  = !fifo_full && !flush && !rst;
  assign in_fire   = in_valid && in_ready;
  assign fifo_push = in_fire && ev_ok;
  // Must mirror the load conditions of the output FSM below.
  assign fifo_pop  = !fifo_empty && !flush && !rst &&
                     ((state == OUT_EMPTY) || out_ready);
  assign fifo_head = event_t'(fifo_head_raw);

  event_fifo #(
    .WIDTH ($bits(event_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (fifo_push),
    .wdata (in_event),
    .pop   (fifo_pop),
    .rdata (fifo_head_raw),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign fill_level = fifo_count + FILL_W'(out_valid);

  // Output stage: holds one event stable until the conv accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= OUT_EMPTY;
      out_valid <= 1'b0;
      out_event <= '0;
    end else if (flush) begin
      state     <= OUT_EMPTY;
      out_valid <= 1'b0;
    end else begin
      case (state)
        OUT_EMPTY: begin
          if (!fifo_empty) begin
            out_event <= fifo_head;
            out_valid <= 1'b1;
            state     <= OUT_LOADED;
          end
        end
        OUT_LOADED: begin
          if (out_ready) begin
            if (!fifo_empty) begin
              out_event <= fifo_head;
            end else begin
              out_valid <= 1'b0;
              state     <= OUT_EMPTY;
            end
          end
        end
        default: begin
          state     <= OUT_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of events consumed but discarded by the filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (in_fire && !ev_ok && (drop_count != '1)) begin
      drop_count <= drop_count + DROP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_event_capture_tx.sv
// Scoreboard bench for event_capture_tx: senders push expected events, a
// negedge monitor pops and compares every output transfer.
module tb_event_capture_tx;
  import snn_interfaces_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  event_t      in_event = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  event_t      out_event;
  logic        flush = 1'b0;
  logic [3:0]  fill_level;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;
  event_t exp_q[$];

  always #5 clk = ~clk;

  event_capture_tx dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_event   (in_event),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_event  (out_event),
    .flush      (flush),
    .fill_level (fill_level),
    .drop_count (drop_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit good(input event_t e);
    return (e.x < 8'd32) && (e.y < 8'd32) && (e.spikes != 2'b00);
  endfunction

  function automatic event_t mk(input int x, input int y, input int s);
    event_t e;
    e.x = 8'(x);
    e.y = 8'(y);
    e.spikes = 2'(s);
    return e;
  endfunction

  // Offer once for a single cycle; report whether the handshake happened.
  task automatic send_once(input event_t e, output bit acc);
    in_valid = 1'b1;
    in_event = e;
    @(negedge clk);
    acc = in_ready;
    if (acc && good(e)) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Hold the event until accepted, bounded.
  task automatic send_wait(input event_t e);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_event = e;
    for (int t = 0; t < 60 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        if (good(e)) exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares each transfer and checks stability while stalled.
  event_t prev_ev;
  bit     prev_stall = 1'b0;
  always @(negedge clk) begin
    event_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_event", 32'(out_event), 32'(prev_ev));
      end
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(out_event), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_event", 32'(out_event), 32'(e));
        end
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_ev    = out_event;
    end
  end

  initial begin
    bit acc;
    int n_acc;
    bit done;

    // 1. reset
    tick(2);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 2. single event latency
    out_ready = 1'b1;
    send_wait(mk(3, 5, 1));
    chk("lat_n1_valid", 32'(out_valid), 32'd0);
    tick(1);
    chk("lat_n2_valid", 32'(out_valid), 32'd1);
    chk("lat_x", 32'(out_event.x), 32'd3);
    chk("lat_y", 32'(out_event.y), 32'd5);
    chk("lat_spikes", 32'(out_event.spikes), 32'd1);
    chk("lat_fill", 32'(fill_level), 32'd1);
    tick(1);
    chk("single_width", 32'(out_valid), 32'd0);
    chk("single_fill", 32'(fill_level), 32'd0);

    // 3. burst of 12 against a stalled consumer
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      send_once(mk(i + 1, 31 - i, (i % 3) + 1), acc);
      n_acc += int'(acc);
    end
    chk("burst_accepted", 32'(n_acc), 32'd9);
    chk("burst_in_ready", 32'(in_ready), 32'd0);
    chk("burst_fill", 32'(fill_level), 32'd9);
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("b2b_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    chk("b2b_end", 32'(out_valid), 32'd0);
    tick(1);
    chk("burst_drained", 32'(exp_q.size()), 32'd0);

    // 4. filter drops
    send_once(mk(32, 1, 1), acc);
    chk("drop_x_hs", 32'(acc), 32'd1);
    send_once(mk(1, 40, 1), acc);
    chk("drop_y_hs", 32'(acc), 32'd1);
    send_once(mk(2, 2, 0), acc);
    chk("drop_s_hs", 32'(acc), 32'd1);
    tick(4);
    chk("drop_count3", 32'(drop_count), 32'd3);
    chk("drop_fill", 32'(fill_level), 32'd0);

    // 5. flush with 5 buffered
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_wait(mk(10 + i, 20, 2));
    tick(2);
    chk("preflush_valid", 32'(out_valid), 32'd1);
    chk("preflush_fill", 32'(fill_level), 32'd5);
    flush = 1'b1;
    in_valid = 1'b1;
    in_event = mk(7, 7, 3);
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_fill", 32'(fill_level), 32'd0);
    chk("flush_drop", 32'(drop_count), 32'd3);
    out_ready = 1'b1;
    send_wait(mk(30, 29, 3));
    tick(3);
    chk("postflush_drained", 32'(exp_q.size()), 32'd0);

    // 6. random back-pressure, 1000 events
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++)
          send_wait(mk($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(1, 3)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) tick(1);
    tick(2);
    chk("random_drained", 32'(exp_q.size()), 32'd0);
    chk("random_drop", 32'(drop_count), 32'd3);

    // 7. drop counter saturation
    in_valid = 1'b1;
    in_event = mk(4, 4, 0);
    tick(100);
    chk("drop_mid", 32'(drop_count), 32'd103);
    tick(65441);
    in_valid = 1'b0;
    chk("drop_sat", 32'(drop_count), 32'hFFFF);
    tick(2);
    chk("drop_sat_hold", 32'(drop_count), 32'hFFFF);

    // 8. reset mid-operation
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_wait(mk(i, i, 1));
    tick(2);
    chk("prerst_fill", 32'(fill_level), 32'd3);
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_fill", 32'(fill_level), 32'd0);
    chk("midrst_drop", 32'(drop_count), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick(3);
    chk("midrst_no_output", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
